// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA framebuffer reader.
// Default raster geometry and the colour-select encoding used by the output stage.
package vga_pkg;

  localparam int RGB_WIDTH = 10;
  localparam int H_SIZE    = 10;
  localparam int V_SIZE    = 10;

  typedef struct packed {
    logic [RGB_WIDTH-1:0] r;
    logic [RGB_WIDTH-1:0] g;
    logic [RGB_WIDTH-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    SEL_BLANK,
    SEL_BORDER,
    SEL_FG,
    SEL_BG
  } color_sel_e;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous clear.
// Used to keep raster sideband aligned with RAM read data.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_q[gi] <= '0;
      end else begin
        stage_q[gi] <= stage_d[gi];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader.sv
// Overlays a packed monochrome framebuffer window on the VGA raster, issuing
// one RAM read per word and colouring pixels RAM_LAT+1 cycles after the raster.
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int RGB_WIDTH = vga_pkg::RGB_WIDTH,
  parameter int H_SIZE    = vga_pkg::H_SIZE,
  parameter int V_SIZE    = vga_pkg::V_SIZE,
  parameter int FB_W      = 512,
  parameter int FB_H      = 256,
  parameter int X_OFF     = 64,
  parameter int Y_OFF     = 112,
  parameter int WORD_W    = 16,
  parameter int RAM_LAT   = 1,
  parameter int ADDR_W    = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   display_on,
  input  logic                   vga_hsync,
  input  logic                   vga_vsync,
  input  logic [H_SIZE-1:0]      x_addr,
  input  logic [V_SIZE-1:0]      y_addr,
  input  logic                   cfg_invert,
  input  logic [3*RGB_WIDTH-1:0] fg_color,
  input  logic [3*RGB_WIDTH-1:0] bg_color,
  input  logic [3*RGB_WIDTH-1:0] border_color,
  output logic                   hsync,
  output logic                   vsync,
  output logic [RGB_WIDTH-1:0]   r,
  output logic [RGB_WIDTH-1:0]   g,
  output logic [RGB_WIDTH-1:0]   b,
  output logic                   frame_done,
  output logic                   ram_rd,
  output logic [ADDR_W-1:0]      ram_addr,
  input  logic [WORD_W-1:0]      ram_rdata
);

  localparam int PIX_W = $clog2(FB_W * FB_H);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [H_SIZE:0] X_BEG = (H_SIZE+1)'(X_OFF);
  localparam logic [H_SIZE:0] X_END = (H_SIZE+1)'(X_OFF + FB_W);
  localparam logic [V_SIZE:0] Y_BEG = (V_SIZE+1)'(Y_OFF);
  localparam logic [V_SIZE:0] Y_END = (V_SIZE+1)'(Y_OFF + FB_H);

  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             disp;
    logic             in_win;
    logic [BIT_W-1:0] bit_idx;
    logic             rd;
    logic             last;
  } sb_t;

  logic [H_SIZE-1:0] wx;
  logic [V_SIZE-1:0] wy;
  logic              in_win;
  logic [PIX_W-1:0]  pix;
  logic [BIT_W-1:0]  bit_idx;
  logic              last_pix;
  sb_t               sb_in;
  sb_t               sb_out;

  assign wx = x_addr - H_SIZE'(X_OFF);
  assign wy = y_addr - V_SIZE'(Y_OFF);
  assign in_win = ({1'b0, x_addr} >= X_BEG) && ({1'b0, x_addr} < X_END) &&
                  ({1'b0, y_addr} >= Y_BEG) && ({1'b0, y_addr} < Y_END);
  assign pix      = PIX_W'(wy) * PIX_W'(FB_W) + PIX_W'(wx);
  assign bit_idx  = pix[BIT_W-1:0];
  assign last_pix = in_win && (wx == H_SIZE'(FB_W - 1)) && (wy == V_SIZE'(FB_H - 1));

  // Reads ignore display_on so the word buffer stays in step with the raster.
  assign ram_rd   = in_win && (bit_idx == '0);
  assign ram_addr = ram_rd ? ADDR_W'(pix >> BIT_W) : '0;

  assign sb_in = '{hsync:   vga_hsync,
                   vsync:   vga_vsync,
                   disp:    display_on,
                   in_win:  in_win,
                   bit_idx: bit_idx,
                   rd:      ram_rd,
                   last:    last_pix};

  vga_delay_line #(
    .WIDTH($bits(sb_t)),
    .DEPTH(RAM_LAT)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sb_in),
    .dout (sb_out)
  );

  logic [WORD_W-1:0]      word_reg_q, word_reg_d;
  logic [WORD_W-1:0]      cur_word;
  logic                   pix_bit;
  color_sel_e             sel;
  logic [3*RGB_WIDTH-1:0] eff_fg, eff_bg;
  logic [3*RGB_WIDTH-1:0] rgb_q, rgb_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   frame_done_q, frame_done_d;

  always_comb begin
    cur_word   = sb_out.rd ? ram_rdata : word_reg_q;
    word_reg_d = cur_word;
    pix_bit    = cur_word[sb_out.bit_idx];

    eff_fg = cfg_invert ? bg_color : fg_color;
    eff_bg = cfg_invert ? fg_color : bg_color;

    if (!sb_out.disp)        sel = SEL_BLANK;
    else if (!sb_out.in_win) sel = SEL_BORDER;
    else if (pix_bit)        sel = SEL_FG;
    else                     sel = SEL_BG;

    case (sel)
      SEL_BORDER: rgb_d = border_color;
      SEL_FG:     rgb_d = eff_fg;
      SEL_BG:     rgb_d = eff_bg;
      default:    rgb_d = '0;
    endcase

    hsync_d      = sb_out.hsync;
    vsync_d      = sb_out.vsync;
    frame_done_d = sb_out.last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg_q   <= '0;
      rgb_q        <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      word_reg_q   <= word_reg_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign r          = rgb_q[3*RGB_WIDTH-1 -: RGB_WIDTH];
  assign g          = rgb_q[2*RGB_WIDTH-1 -: RGB_WIDTH];
  assign b          = rgb_q[RGB_WIDTH-1:0];
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: one instance at RAM_LAT=1 and one at RAM_LAT=3
// sharing the raster, each with its own registered RAM model.
module tb_vga_fb_reader;

  localparam logic [29:0] FG = 30'h3FF00000;
  localparam logic [29:0] BG = 30'h000003FF;
  localparam logic [29:0] BD = 30'h000FFC00;

  logic        clk;
  logic        rst_n;
  logic        display_on;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [9:0]  x_addr;
  logic [9:0]  y_addr;
  logic        cfg_invert;
  logic [29:0] fg_color;
  logic [29:0] bg_color;
  logic [29:0] border_color;

  logic        hsync1, vsync1, fd1, rd1;
  logic [9:0]  r1, g1, b1;
  logic [12:0] addr1;
  logic [15:0] rdata1;

  logic        hsync3, vsync3, fd3, rd3;
  logic [9:0]  r3, g3, b3;
  logic [12:0] addr3;
  logic [15:0] rdata3, p3a, p3b;

  logic [15:0] mem [8192];

  int total = 0;
  int bad   = 0;

  vga_fb_reader #(.RAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .display_on(display_on),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .x_addr(x_addr), .y_addr(y_addr), .cfg_invert(cfg_invert),
    .fg_color(fg_color), .bg_color(bg_color), .border_color(border_color),
    .hsync(hsync1), .vsync(vsync1), .r(r1), .g(g1), .b(b1),
    .frame_done(fd1), .ram_rd(rd1), .ram_addr(addr1), .ram_rdata(rdata1)
  );

  vga_fb_reader #(.RAM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .display_on(display_on),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .x_addr(x_addr), .y_addr(y_addr), .cfg_invert(cfg_invert),
    .fg_color(fg_color), .bg_color(bg_color), .border_color(border_color),
    .hsync(hsync3), .vsync(vsync3), .r(r3), .g(g3), .b(b3),
    .frame_done(fd3), .ram_rd(rd3), .ram_addr(addr3), .ram_rdata(rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata1 <= mem[addr1];
    p3a    <= mem[addr3];
    p3b    <= p3a;
    rdata3 <= p3b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int x, input int y);
    x_addr = 10'(x);
    y_addr = 10'(y);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int px [4] = '{63, 576, 64, 63};
  int py [4] = '{112, 112, 111, 112};

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0]    = 16'h8001;
    mem[5]    = 16'h0004;
    mem[8]    = 16'hFFFF;
    mem[9]    = 16'h0001;
    mem[8191] = 16'h8000;

    rst_n = 1'b0; display_on = 1'b0; vga_hsync = 1'b0; vga_vsync = 1'b0;
    x_addr = '0; y_addr = '0; cfg_invert = 1'b0;
    fg_color = FG; bg_color = BG; border_color = BD;

    // reset state
    tick();
    chk("rst_rgb1", {r1, g1, b1}, 30'h0);
    chk("rst_rgb3", {r3, g3, b3}, 30'h0);
    chk("rst_hs1", hsync1, 1'b0);
    chk("rst_vs1", vsync1, 1'b0);
    chk("rst_fd1", fd1, 1'b0);
    rst_n = 1'b1;
    display_on = 1'b1;
    tick();

    // word 0 = 8001: pixel 0 and 15 fg, rest bg; reads only at word starts
    for (int i = 0; i <= 16; i++) begin
      put(64 + i, 112);
      chk("t1_rd", rd1, (i == 0 || i == 16) ? 1'b1 : 1'b0);
      if (i == 0)  chk("t1_addr0", addr1, 13'd0);
      if (i == 16) chk("t1_addr1", addr1, 13'd1);
      tick();
      if (i >= 1) chk("t1_pix", {r1, g1, b1}, ((i - 1) == 0 || (i - 1) == 15) ? FG : BG);
    end

    // RAM_LAT=3: word 5 = 0004, pixel x=146 fg after 4 cycles, hsync delayed
    for (int i = 0; i < 8; i++) begin
      vga_hsync = (i == 1);
      put(144 + i, 112);
      if (i == 0) begin
        chk("t2_rd3", rd3, 1'b1);
        chk("t2_addr3", addr3, 13'd5);
      end
      tick();
      if (i >= 2) chk("t2_hs1", hsync1, (i == 2) ? 1'b1 : 1'b0);
      if (i >= 3) begin
        chk("t2_pix3", {r3, g3, b3}, (i - 3 == 2) ? FG : BG);
        chk("t2_hs3", hsync3, (i == 4) ? 1'b1 : 1'b0);
      end
    end
    vga_hsync = 1'b0;

    // just outside the window: border when displayed, 0 when blanked
    for (int d = 1; d >= 0; d--) begin
      display_on = (d == 1);
      for (int j = 0; j < 4; j++) begin
        put(px[j], py[j]);
        chk("t3_rd", rd1, 1'b0);
        tick();
        if (j >= 1) chk(d == 1 ? "t3_border" : "t3_blank", {r1, g1, b1}, d == 1 ? BD : 30'h0);
      end
    end
    display_on = 1'b1;

    // invert with an all-zero word gives the (swapped) foreground everywhere
    cfg_invert = 1'b1; fg_color = 30'h3FFFFFFF; bg_color = 30'h0;
    for (int i = 0; i < 6; i++) begin
      put(96 + i, 112);
      tick();
      if (i >= 1) chk("t4_inv", {r1, g1, b1}, 30'h3FFFFFFF);
    end
    cfg_invert = 1'b0; fg_color = FG; bg_color = BG;

    // last word and frame_done on pixel (575,367)
    for (int i = 0; i < 18; i++) begin
      put(560 + i, 367);
      if (i == 0) begin
        chk("t5_rd", rd1, 1'b1);
        chk("t5_addr", addr1, 13'd8191);
      end
      if (i == 16) chk("t5_rd_out", rd1, 1'b0);
      tick();
      if (i >= 1) begin
        chk("t5_fd", fd1, (559 + i == 575) ? 1'b1 : 1'b0);
        if (559 + i == 575) chk("t5_lastpix", {r1, g1, b1}, FG);
      end
    end

    // reset mid-line at x=200
    for (int x = 192; x < 200; x++) begin
      put(x, 112);
      tick();
    end
    chk("t6_pre", {r1, g1, b1}, FG);
    put(200, 112);
    rst_n = 1'b0;
    #1;
    chk("t6_async1", {r1, g1, b1}, 30'h0);
    chk("t6_async3", {r3, g3, b3}, 30'h0);
    tick();
    put(201, 112);
    tick();
    put(202, 112);
    tick();
    chk("t6_held", {r1, g1, b1}, 30'h0);
    rst_n = 1'b1;
    put(203, 112);
    tick();
    for (int x = 204; x <= 210; x++) begin
      put(x, 112);
      if (x == 208) begin
        chk("t6_rd", rd1, 1'b1);
        chk("t6_addr", addr1, 13'd9);
      end
      tick();
      chk("t6_pix", {r1, g1, b1}, (x - 1 == 208) ? FG : BG);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Parametrised successor to the Hack screen controller.
- Maps a monochrome framebuffer of FB_W x FB_H pixels, packed WORD_W pixels per RAM word, into a window at (X_OFF, Y_OFF) on the VGA raster.
- Supports configurable RAM read latency, one RAM read per word instead of per pixel, runtime foreground/background/border colours, an invert mode, and an end-of-frame pulse.
- Sits between the VGA timing generator and the screen RAM read port.

Parameters:
- RGB_WIDTH, 10, bits per colour channel.
- H_SIZE, 10, width of x_addr.
- V_SIZE, 10, width of y_addr.
- FB_W, 512, framebuffer width in pixels; must be a multiple of WORD_W.
- FB_H, 256, framebuffer height in pixels.
- X_OFF, 64, raster x of the framebuffer's left column.
- Y_OFF, 112, raster y of the framebuffer's top row.
- WORD_W, 16, pixels per RAM word; power of two.
- RAM_LAT, 1, RAM read latency in cycles; legal range 1..4.
- ADDR_W, 13, RAM word address width; must be at least log2(FB_W*FB_H/WORD_W).

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- display_on, input, 1, high in the active video region.
- vga_hsync, input, 1, raw hsync from the timing generator.
- vga_vsync, input, 1, raw vsync from the timing generator.
- x_addr, input, H_SIZE, raster pixel x.
- y_addr, input, V_SIZE, raster pixel y.
- cfg_invert, input, 1, swaps fg and bg.
- fg_color, input, 3*RGB_WIDTH, {r,g,b} colour for a pixel bit of 1.
- bg_color, input, 3*RGB_WIDTH, {r,g,b} colour for a pixel bit of 0.
- border_color, input, 3*RGB_WIDTH, colour outside the window while display_on is high.
- hsync, output, 1, delayed hsync.
- vsync, output, 1, delayed vsync.
- r, output, RGB_WIDTH, red channel.
- g, output, RGB_WIDTH, green channel.
- b, output, RGB_WIDTH, blue channel.
- frame_done, output, 1, one-cycle pulse aligned with the last window pixel.
- ram_rd, output, 1, read strobe.
- ram_addr, output, ADDR_W, word address.
- ram_rdata, input, WORD_W, read data valid RAM_LAT cycles after ram_rd.

Behaviour:
- Reset is asynchronous, active-low. While asserted:
  - hsync, vsync, r, g, b and frame_done are 0.
  - All pipeline stages and word_reg are 0.
- ram_rd and ram_addr are combinational from x_addr and y_addr.
- Window decode (combinational):
  - wx = x_addr - X_OFF; wy = y_addr - Y_OFF.
  - in_win = (X_OFF <= x_addr < X_OFF+FB_W) and (Y_OFF <= y_addr < Y_OFF+FB_H).
  - pix = wy*FB_W + wx, computed in log2(FB_W*FB_H) bits with no overflow.
  - bit_idx = pix mod WORD_W.
- Read issue:
  - ram_rd = in_win and bit_idx == 0, independent of display_on, so the word buffer never goes stale.
  - ram_addr = pix / WORD_W when ram_rd is high, else 0.
- Delay line: RAM_LAT stages carry hsync, vsync, display_on, in_win, bit_idx, rd_issued and last_pix.
  - last_pix = in_win and wx == FB_W-1 and wy == FB_H-1.
- Word select at stage RAM_LAT:
  - If rd_issued is set, cur_word = ram_rdata and word_reg <= ram_rdata.
  - Otherwise cur_word = word_reg.
  - pixel bit = cur_word[bit_idx].
- Colour:
  - eff_fg = cfg_invert ? bg_color : fg_color; eff_bg is the opposite.
  - Selected colour: display_on low gives 0; in_win low gives border_color; pixel bit 1 gives eff_fg; pixel bit 0 gives eff_bg.
  - The result is registered.
  - Total latency from x_addr/y_addr/vga_* to r/g/b/hsync/vsync/frame_done is RAM_LAT+1 cycles.
- Colour-input changes take effect on pixels reaching the output register stage; no synchronisation is applied.
- Pixel stream rules:
  - Raster x advances one pixel per clk inside a line.
  - A window row starts on a word boundary, so the first pixel of every row issues a read.
- Boundaries:
  - x just outside the window (X_OFF-1 or X_OFF+FB_W): border colour, no read.
  - Last word of the frame reads address FB_W*FB_H/WORD_W-1; there is no wrap.
  - display_on dropping mid-word: output goes 0 immediately at its pipeline stage; reads continue.
  - Reset mid-line: outputs clear asynchronously. After release, the first correct word is fetched at the next word boundary. Pixels before that show word_reg = 0, i.e. bg colour.
- frame_done pulses exactly once per frame, provided the raster covers the window.

Decomposition:
- Package vga_pkg holds:
  - H_SIZE and V_SIZE constants.
  - typedef rgb_t, a struct of r, g and b each RGB_WIDTH wide.
  - Enum color_sel_e {SEL_BLANK, SEL_BORDER, SEL_FG, SEL_BG}.
- One sub-module: vga_delay_line (parameters WIDTH and DEPTH, with async reset to 0). It is instantiated once for the bundled sideband fields.

Test Plan:
- Defaults, RAM_LAT=1; RAM word 0 = 16'h8001; raster at (64,112) and onward -> ram_rd only at x=64; addr 0. At cycles +2 and +17, r/g/b = fg; pixels 1..14 = bg.
- RAM_LAT=3, word 5 = 16'h0004 -> read of addr 5 at x=144, y=112. Pixel x=146 appears 4 cycles later with fg colour; hsync is delayed 4 cycles.
- Raster (63,112), (576,112), (64,111) with display_on=1 -> border_color, no ram_rd. Same points with display_on=0 -> 0.
- cfg_invert=1, fg=30'h3FFFFFFF, bg=0, word all zeros -> all window pixels output 30'h3FFFFFFF.
- Last pixel (575,367) -> ram_addr 8191 at x=560; frame_done high for exactly one cycle, coincident with that pixel's rgb.
- rst_n asserted mid-line at x=200 for 3 cycles -> outputs 0 asynchronously. After release, bg colour until x=208, which reads and displays correct data.
